// File: rtl/video_pkg.sv
// Shared definitions for the video capture/playback paths: pack geometry,
// default frame size and the DMA state encoding.
package video_pkg;

    localparam int NBPACK      = 16;
    localparam int p_WIDTH     = 640;
    localparam int p_HEIGHT    = 480;
    localparam int FRAME_BYTES = p_WIDTH * p_HEIGHT;
    localparam int INT_CYCLES  = 4;

    typedef enum logic [2:0] {
        WAIT_ADDR       = 3'd0,
        READ_FIFO       = 3'd1,
        WB_WRITE        = 3'd2,
        WB_GAP          = 3'd3,
        IMAGE_PROCESSED = 3'd4
    } video_state_t;

endpackage

// File: rtl/pixel_packer.sv
// Pack buffer for the capture DMA: NBPACK byte registers written one pixel at a
// time, read back as big-endian 32-bit words (lowest pixel index in [31:24]).
module pixel_packer #(
    parameter int NBPACK = 16,
    parameter int PIW    = $clog2(NBPACK),
    parameter int WIW    = (PIW > 2) ? PIW - 2 : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [PIW-1:0]  idx,
    input  logic [7:0]      pixel,
    input  logic [WIW-1:0]  word_idx,
    output logic [31:0]     word
);

    logic [7:0]     pack [NBPACK];
    logic [PIW-1:0] base_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NBPACK; i++) pack[i] <= '0;
        end else if (we) begin
            pack[idx] <= pixel;
        end
    end

    assign base_idx = PIW'({word_idx, 2'b00});
    assign word = {pack[base_idx],
                   pack[base_idx + PIW'(1)],
                   pack[base_idx + PIW'(2)],
                   pack[base_idx + PIW'(3)]};

endmodule

// File: rtl/video_in_write.sv
// Video capture DMA: pops FIFO pixels into a pack, writes packs to RAM as 32-bit
// Wishbone writes, pulses interrupt at frame end. Define VIDEO_IN_WRITE_LOCK_EN to
// hold CYC/LOCK across all words of a pack.
//   state           | meaning
//   WAIT_ADDR       | idle, waiting for control bit0 rising edge
//   READ_FIFO       | popping pixels into the pack buffer
//   WB_WRITE        | one word on the bus, waiting for ACK
//   WB_GAP          | one idle bus cycle between words of a pack
//   IMAGE_PROCESSED | frame written, interrupt high
module video_in_write #(
    parameter int NBPACK   = video_pkg::NBPACK,
    parameter int p_WIDTH  = video_pkg::p_WIDTH,
    parameter int p_HEIGHT = video_pkg::p_HEIGHT
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic [31:0] wb_reg_data,
    input  logic [31:0] wb_reg_ctr,
    output logic        interrupt,
    output logic [31:0] p_wb_DAT_O,
    input  logic        p_wb_ACK_I,
    output logic        p_wb_STB_O,
    output logic        p_wb_CYC_O,
    output logic        p_wb_LOCK_O,
    output logic [3:0]  p_wb_SEL_O,
    output logic        p_wb_WE_O,
    output logic [31:0] p_wb_ADR_O,
    input  logic        empty,
    output logic        r_e,
    input  logic [7:0]  pixel_in
);

    import video_pkg::video_state_t;
    import video_pkg::WAIT_ADDR;
    import video_pkg::READ_FIFO;
    import video_pkg::WB_WRITE;
    import video_pkg::WB_GAP;
    import video_pkg::IMAGE_PROCESSED;
    import video_pkg::INT_CYCLES;

    localparam int PIW = $clog2(NBPACK);
    localparam int WIW = (PIW > 2) ? PIW - 2 : 1;
    localparam logic [PIW-1:0] LAST_PIX  = PIW'(NBPACK - 1);
    localparam logic [WIW-1:0] LAST_WORD = WIW'(NBPACK / 4 - 1);
    localparam logic [19:0]    FRAME_LEN = 20'(p_WIDTH * p_HEIGHT);
    localparam logic [1:0]     INT_LAST  = 2'(INT_CYCLES - 1);

    video_state_t   state, state_nxt;
    logic           ctr0_q;
    logic [31:0]    base;
    logic [PIW-1:0] pack_cnt;
    logic [WIW-1:0] word_cnt;
    logic [19:0]    byte_cnt;
    logic [1:0]     int_cnt;
    logic           start;
    logic           pop;
    logic           frame_end;
    logic [31:0]    word;
    logic           unused_bits;

    assign start       = wb_reg_ctr[0] & ~ctr0_q;
    assign pop         = (state == READ_FIFO) & ~empty;
    assign frame_end   = (byte_cnt + 20'd4) == FRAME_LEN;
    assign unused_bits = ^{wb_reg_ctr[31:1], wb_reg_data[1:0]};
    assign p_wb_SEL_O  = 4'hf;

    pixel_packer #(
        .NBPACK (NBPACK),
        .PIW    (PIW),
        .WIW    (WIW)
    ) u_packer (
        .clk      (clk),
        .rst_n    (nRST),
        .we       (pop),
        .idx      (pack_cnt),
        .pixel    (pixel_in),
        .word_idx (word_cnt),
        .word     (word)
    );

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) state <= WAIT_ADDR;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_ADDR:       if (start) state_nxt = READ_FIFO;
            READ_FIFO:       if (pop && pack_cnt == LAST_PIX) state_nxt = WB_WRITE;
            WB_WRITE: begin
                if (p_wb_ACK_I) begin
                    if (word_cnt == LAST_WORD)
                        state_nxt = frame_end ? IMAGE_PROCESSED : READ_FIFO;
                    else
                        state_nxt = WB_GAP;
                end
            end
            WB_GAP:          state_nxt = WB_WRITE;
            IMAGE_PROCESSED: if (int_cnt == INT_LAST) state_nxt = WAIT_ADDR;
            default:         state_nxt = WAIT_ADDR;
        endcase
    end

    // Control bit0 is sampled every cycle so a level held high never re-triggers.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            ctr0_q   <= 1'b0;
            base     <= '0;
            pack_cnt <= '0;
            word_cnt <= '0;
            byte_cnt <= '0;
            int_cnt  <= '0;
        end else begin
            ctr0_q <= wb_reg_ctr[0];
            case (state)
                WAIT_ADDR: begin
                    if (start) begin
                        base     <= {wb_reg_data[31:2], 2'b00};
                        pack_cnt <= '0;
                        word_cnt <= '0;
                        byte_cnt <= '0;
                        int_cnt  <= '0;
                    end
                end
                READ_FIFO: begin
                    if (pop) pack_cnt <= (pack_cnt == LAST_PIX) ? '0 : pack_cnt + 1'b1;
                end
                WB_WRITE: begin
                    if (p_wb_ACK_I) begin
                        byte_cnt <= byte_cnt + 20'd4;
                        word_cnt <= (word_cnt == LAST_WORD) ? '0 : word_cnt + 1'b1;
                    end
                end
                IMAGE_PROCESSED: begin
                    if (int_cnt == INT_LAST) begin
                        int_cnt  <= '0;
                        byte_cnt <= '0;
                    end else begin
                        int_cnt <= int_cnt + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        p_wb_STB_O  = 1'b0;
        p_wb_CYC_O  = 1'b0;
        p_wb_LOCK_O = 1'b0;
        p_wb_WE_O   = 1'b0;
        p_wb_ADR_O  = '0;
        p_wb_DAT_O  = '0;
        r_e         = 1'b0;
        interrupt   = 1'b0;
        case (state)
            READ_FIFO: r_e = ~empty;
            WB_WRITE: begin
                p_wb_STB_O = 1'b1;
                p_wb_CYC_O = 1'b1;
                p_wb_WE_O  = 1'b1;
                p_wb_ADR_O = base + {12'd0, byte_cnt};
                p_wb_DAT_O = word;
`ifdef VIDEO_IN_WRITE_LOCK_EN
                p_wb_LOCK_O = 1'b1;
`endif
            end
            WB_GAP: begin
`ifdef VIDEO_IN_WRITE_LOCK_EN
                p_wb_CYC_O  = 1'b1;
                p_wb_LOCK_O = 1'b1;
`endif
            end
            IMAGE_PROCESSED: interrupt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_video_in_write.sv
// Directed bench for video_in_write on a reduced 32x2 frame (16 words, 4 packs),
// with a first-word-fall-through FIFO model and a latency-programmable ACK slave.
`timescale 1ns/1ps
module tb_video_in_write;

    localparam int W           = 32;
    localparam int H           = 2;
    localparam int NB          = 16;
    localparam int FRAME_WORDS = W * H / 4;
`ifdef VIDEO_IN_WRITE_LOCK_EN
    localparam logic [31:0] LOCK_EN = 32'd1;
`else
    localparam logic [31:0] LOCK_EN = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        nRST;
    logic [31:0] wb_reg_data;
    logic [31:0] wb_reg_ctr;
    logic        interrupt;
    logic [31:0] p_wb_DAT_O;
    logic        p_wb_STB_O;
    logic        p_wb_CYC_O;
    logic        p_wb_LOCK_O;
    logic [3:0]  p_wb_SEL_O;
    logic        p_wb_WE_O;
    logic [31:0] p_wb_ADR_O;
    logic        empty = 1'b0;
    logic        r_e;
    logic [7:0]  pixel_in;

    int          n_vec = 0;
    int          n_mis = 0;
    logic        empty_mode = 1'b0;
    int          ack_lat = 1;
    logic [31:0] exp_base = '0;
    logic [7:0]  pix_idx = '0;
    logic [7:0]  popq [$];
    logic        pop_pending = 1'b0;
    logic        ack = 1'b0;
    logic        gap_exp = 1'b0;
    int          wait_cnt = 0;
    int          wr_cnt = 0;
    int          int_run = 0;
    int          int_done = 0;
    logic [31:0] last_adr = '0;

    always #5 clk = ~clk;
    assign pixel_in = pix_idx;

    video_in_write #(
        .NBPACK   (NB),
        .p_WIDTH  (W),
        .p_HEIGHT (H)
    ) dut (
        .clk         (clk),
        .nRST        (nRST),
        .wb_reg_data (wb_reg_data),
        .wb_reg_ctr  (wb_reg_ctr),
        .interrupt   (interrupt),
        .p_wb_DAT_O  (p_wb_DAT_O),
        .p_wb_ACK_I  (ack),
        .p_wb_STB_O  (p_wb_STB_O),
        .p_wb_CYC_O  (p_wb_CYC_O),
        .p_wb_LOCK_O (p_wb_LOCK_O),
        .p_wb_SEL_O  (p_wb_SEL_O),
        .p_wb_WE_O   (p_wb_WE_O),
        .p_wb_ADR_O  (p_wb_ADR_O),
        .empty       (empty),
        .r_e         (r_e),
        .pixel_in    (pixel_in)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Empty changes only on the rising edge so r_e is stable over the whole low phase.
    always @(posedge clk) empty <= empty_mode ? ~empty : 1'b0;

    // FIFO pop accounting, ACK slave and write scoreboard, all sampled mid-cycle.
    always @(negedge clk) begin
        if (pop_pending) begin
            popq.push_back(pix_idx);
            pix_idx <= pix_idx + 8'd1;
        end
        pop_pending <= nRST & r_e;
        if (!nRST) begin
            popq.delete();
            ack      <= 1'b0;
            gap_exp  <= 1'b0;
            wait_cnt <= 0;
            wr_cnt   <= 0;
            int_run  <= 0;
        end else begin
            if (empty) chk("re_while_empty", 32'(r_e), 0);
            if (gap_exp) begin
                chk("gap_stb", 32'(p_wb_STB_O), 0);
                chk("gap_cyc", 32'(p_wb_CYC_O), LOCK_EN);
                chk("gap_lock", 32'(p_wb_LOCK_O), LOCK_EN);
            end
            if (p_wb_STB_O) begin
                chk("stb_re", 32'(r_e), 0);
                chk("stb_cyc", 32'(p_wb_CYC_O), 1);
                chk("stb_we", 32'(p_wb_WE_O), 1);
                chk("stb_lock", 32'(p_wb_LOCK_O), LOCK_EN);
                chk("adr", p_wb_ADR_O, exp_base + 32'(wr_cnt * 4));
                if (popq.size() < 4) chk("pack_ready", popq.size(), 4);
                else chk("dat", p_wb_DAT_O, {popq[0], popq[1], popq[2], popq[3]});
                if (!ack && wait_cnt == ack_lat) begin
                    ack      <= 1'b1;
                    wait_cnt <= 0;
                    last_adr <= p_wb_ADR_O;
                    if (popq.size() >= 4) repeat (4) void'(popq.pop_front());
                    gap_exp  <= (wr_cnt % 4) != 3;
                    wr_cnt   <= wr_cnt + 1;
                end else begin
                    gap_exp  <= 1'b0;
                    wait_cnt <= wait_cnt + 1;
                end
            end else begin
                if (wait_cnt != 0) chk("stb_dropped_before_ack", wait_cnt, 0);
                if (!gap_exp) begin
                    chk("idle_cyc", 32'(p_wb_CYC_O), 0);
                    chk("idle_lock", 32'(p_wb_LOCK_O), 0);
                end
                ack      <= 1'b0;
                gap_exp  <= 1'b0;
                wait_cnt <= 0;
            end
            if (interrupt) begin
                if (int_run == 0) chk("frame_words", wr_cnt, FRAME_WORDS);
                int_run <= int_run + 1;
            end else if (int_run != 0) begin
                chk("int_len", int_run, 4);
                chk("q_left", popq.size(), 0);
                int_run  <= 0;
                int_done <= int_done + 1;
                wr_cnt   <= 0;
            end
        end
    end

    task automatic start_frame(input logic [31:0] addr);
        @(negedge clk);
        wb_reg_ctr = 32'h0;
        @(negedge clk);
        wb_reg_data = addr;
        wb_reg_ctr  = 32'h1;
        chk("start_pre_re", 32'(r_e), 0);
        @(negedge clk);
        chk("start_re", 32'(r_e), 1);
    endtask

    task automatic wait_frame(input string tag);
        int d0 = int_done;
        for (int i = 0; i < 4000 && int_done == d0; i++) @(negedge clk);
        chk(tag, int_done - d0, 1);
    endtask

    initial begin
        nRST        = 1'b0;
        wb_reg_data = '0;
        wb_reg_ctr  = '0;
        #12;
        chk("rst_stb", 32'(p_wb_STB_O), 0);
        chk("rst_cyc", 32'(p_wb_CYC_O), 0);
        chk("rst_lock", 32'(p_wb_LOCK_O), 0);
        chk("rst_we", 32'(p_wb_WE_O), 0);
        chk("rst_re", 32'(r_e), 0);
        chk("rst_int", 32'(interrupt), 0);
        chk("rst_adr", p_wb_ADR_O, 0);
        chk("rst_dat", p_wb_DAT_O, 0);
        chk("sel", 32'(p_wb_SEL_O), 32'hf);
        @(posedge clk);
        #1 nRST = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_re", 32'(r_e), 0);

        // Full frame, ACK one cycle after STB, low address bits ignored.
        exp_base = 32'h1000_0000;
        start_frame(32'h1000_0003);
        wait_frame("frame1_done");
        chk("frame1_last_adr", last_adr, 32'h1000_003C);

        // Idle after frame end with bit0 still high and FIFO non-empty.
        repeat (8) begin
            @(negedge clk);
            chk("post_stb", 32'(p_wb_STB_O), 0);
            chk("post_re", 32'(r_e), 0);
            chk("post_int", 32'(interrupt), 0);
        end

        // FIFO empty every other cycle.
        exp_base = 32'h0000_2000;
        start_frame(32'h0000_2000);
        empty_mode = 1'b1;
        wait_frame("frame_empty_done");
        empty_mode = 1'b0;
        chk("frame_empty_last_adr", last_adr, 32'h0000_203C);

        // Slow slave: ACK 5 cycles after STB.
        ack_lat  = 5;
        exp_base = 32'h0040_0000;
        start_frame(32'h0040_0000);
        wait_frame("frame_slow_done");
        chk("frame_slow_last_adr", last_adr, 32'h0040_003C);
        ack_lat = 1;

        // Second start edge mid-frame is ignored; base stays.
        exp_base = 32'h2000_0000;
        start_frame(32'h2000_0000);
        for (int i = 0; i < 500 && wr_cnt < 3; i++) @(negedge clk);
        wb_reg_ctr = 32'h0;
        @(negedge clk);
        wb_reg_ctr  = 32'h1;
        wb_reg_data = 32'h3000_0000;
        wait_frame("frame_restart_ignored_done");
        chk("frame_restart_last_adr", last_adr, 32'h2000_003C);

        // Reset in the middle of a write drops the bus at once; next frame starts over.
        exp_base = 32'h4000_0000;
        start_frame(32'h4000_0000);
        for (int i = 0; i < 500 && !(wr_cnt >= 5 && p_wb_STB_O); i++) @(negedge clk);
        chk("reset_point_stb", 32'(p_wb_STB_O), 1);
        #2 nRST = 1'b0;
        #1;
        chk("async_rst_stb", 32'(p_wb_STB_O), 0);
        chk("async_rst_cyc", 32'(p_wb_CYC_O), 0);
        chk("async_rst_lock", 32'(p_wb_LOCK_O), 0);
        wb_reg_ctr = 32'h0;
        @(posedge clk);
        @(posedge clk);
        #1 nRST = 1'b1;
        exp_base = 32'h5000_0000;
        start_frame(32'h5000_0000);
        wait_frame("frame_after_reset_done");
        chk("frame_after_reset_last_adr", last_adr, 32'h5000_003C);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
